// File: rtl/uart_tx.sv
// PicoRV32 native-bus UART transmitter: DATA (write byte) and STATUS registers, 8N1 framing.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry transmit FIFO; otherwise a single holding register.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        serial_out
);
  // state   | meaning
  // S_IDLE  | line high, waiting for a buffered byte
  // S_START | start bit (low)
  // S_DATA  | data bits, LSB first, r_bit_idx 0..7
  // S_STOP  | stop bit (high); chains straight into S_START if more data is buffered
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_mem_ready;
  logic [31:0]   r_mem_rdata;
  logic          r_overflow;

  logic        w_access;
  logic        w_is_read;
  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_wr_data;
  logic        w_rd_status;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_baud_tc;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_access     = enable && mem_valid && !r_mem_ready;
  assign w_is_read    = (mem_wstrb == 4'b0000);
  assign w_sel_data   = (mem_addr[3:2] == 2'd0);
  assign w_sel_status = (mem_addr[3:2] == 2'd1);
  assign w_wr_data    = w_access && w_sel_data && mem_wstrb[0];
  assign w_rd_status  = w_access && w_sel_status && w_is_read;
  assign w_push       = w_wr_data && !w_full;
  assign w_baud_tc    = (r_baud_cnt == '0);
  assign w_pop        = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_tc));
  assign w_busy       = (r_state != S_IDLE) || !w_empty;
  assign w_status     = {28'b0, r_overflow, w_empty, w_full, w_busy};
  assign w_unused     = ^{mem_instr, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_vld;

  assign w_empty = !r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_head  = r_hold;

  // Push and pop cannot coincide here: a pop needs the register occupied, which blocks the push.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= mem_wdata[7:0];
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_ready <= w_access;
      r_mem_rdata <= w_rd_status ? w_status : 32'h0;
      if (w_wr_data && w_full) r_overflow <= 1'b1;
      else if (w_rd_status)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state    <= S_START;
            r_baud_cnt <= BAUD_LAST;
            r_shift    <= w_head;
          end
        end
        S_START: begin
          if (w_baud_tc) begin
            r_state    <= S_DATA;
            r_baud_cnt <= BAUD_LAST;
            r_bit_idx  <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_tc) begin
            r_baud_cnt <= BAUD_LAST;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_tc) begin
            if (w_pop) begin
              r_state    <= S_START;
              r_baud_cnt <= BAUD_LAST;
              r_shift    <= w_head;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    serial_out = 1'b1;
    case (r_state)
      S_START: serial_out = 1'b0;
      S_DATA:  serial_out = r_shift[r_bit_idx];
      default: serial_out = 1'b1;
    endcase
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bus accesses drive a byte scoreboard, a line monitor decodes frames.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CPB = 434;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int NB2B = (DEPTH > 1) ? 3 : 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        serial_out;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         last_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus(input logic [1:0] reg_idx, input logic [3:0] wstrb,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = {28'h0, reg_idx, 2'b00};
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    @(posedge clk); #1;
    chk("rdy_hi", {31'h0, mem_ready}, 32'h1);
    rdata    = mem_rdata;
    last_rdy = cyc;
    @(negedge clk);
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rdy_lo", {31'h0, mem_ready}, 32'h0);
  endtask

  task automatic wr(input logic [7:0] b, input bit expect_tx);
    logic [31:0] rd;
    if (expect_tx) exp_q.push_back(b);
    bus(2'd0, 4'b0001, {24'h0, b}, rd);
    chk("data_rd0", rd, 32'h0);
  endtask

  task automatic rd_status(output logic [31:0] rd);
    bus(2'd1, 4'b0000, 32'h0, rd);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  // Line monitor: samples the first and last cycle of every bit slot so bit length is exact.
  initial begin : monitor
    logic [9:0] fst;
    logic [9:0] lst;
    logic [9:0] exp_frm;
    logic [7:0] b;
    bit         aborted;
    @(negedge clk);
    forever begin
      if (resetn && serial_out === 1'b0) begin
        starts.push_back(cyc);
        aborted = 1'b0;
        fst = '0;
        lst = '0;
        for (int t = 0; t < 10 * CPB; t++) begin
          if (t % CPB == 0)       fst[t / CPB] = serial_out;
          if (t % CPB == CPB - 1) lst[t / CPB] = serial_out;
          @(negedge clk);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          chk("frm_expected", {31'h0, exp_q.size() > 0}, 32'h1);
          if (exp_q.size() > 0) begin
            b       = exp_q.pop_front();
            exp_frm = {1'b1, b, 1'b0};
            chk("frm_first", {22'h0, fst}, {22'h0, exp_frm});
            chk("frm_last", {22'h0, lst}, {22'h0, exp_frm});
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : stim
    logic [31:0] rd;
    logic [7:0]  b2b [3];
    int          s;
    int          r;
    int          n;
    bit          seen;
    b2b[0] = 8'h10;
    b2b[1] = 8'h28;
    b2b[2] = 8'h55;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", {31'h0, serial_out}, 32'h1);
    chk("rst_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    rd_status(rd);
    chk("status_idle", rd, 32'h4);

    // enable low: request must be ignored entirely
    s = starts.size();
    @(negedge clk);
    enable    = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wstrb = 4'b0001;
    mem_wdata = 32'h77;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    chk("en_low_ready", {31'h0, seen}, 32'h0);
    rd_status(rd);
    chk("en_low_status", rd, 32'h4);
    repeat (20) @(negedge clk);
    chk("en_low_noframe", starts.size(), s);

    // single frame 0x41, start bit the cycle after the mem_ready cycle
    s = starts.size();
    wr(8'h41, 1'b1);
    r = last_rdy;
    n = 0;
    while (starts.size() <= s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (starts.size() > s) chk("start_latency", starts[s], r + 1);
    else                   chk("start_timeout", starts.size(), s + 1);
    drain(12 * CPB);
    rd_status(rd);
    chk("status_after_41", rd, 32'h4);

    // back-to-back writes -> contiguous frames exactly 10 bit times apart
    s = starts.size();
    for (int i = 0; i < NB2B; i++) wr(b2b[i], 1'b1);
    drain((NB2B + 1) * 10 * CPB);
    if (starts.size() >= s + NB2B) begin
      for (int i = 1; i < NB2B; i++) chk("b2b_gap", starts[s+i] - starts[s+i-1], 10 * CPB);
    end else begin
      chk("b2b_count", starts.size() - s, NB2B);
    end

    // overflow: one byte in flight plus a full buffer, then an extra byte is dropped
    for (int i = 0; i <= DEPTH; i++) wr(8'h30 + 8'(i), 1'b1);
    wr(8'hFF, 1'b0);
    rd_status(rd);
    chk("ovf_status1", rd, 32'hB);
    rd_status(rd);
    chk("ovf_status2", rd, 32'h3);
    drain((DEPTH + 2) * 10 * CPB);
    rd_status(rd);
    chk("status_after_ovf", rd, 32'h4);

    // reset during data bit 3 of 0xA5 with another byte buffered
    wr(8'hA5, 1'b0);
    r = last_rdy;
    wr(8'h5A, 1'b0);
    while (cyc < r + 1 + 4 * CPB + CPB / 2) @(negedge clk);
    chk("pre_reset_bit3", {31'h0, serial_out}, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_serial", {31'h0, serial_out}, 32'h1);
    chk("mid_reset_ready", {31'h0, mem_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    s = starts.size();
    rd_status(rd);
    chk("status_after_reset", rd, 32'h4);
    seen = 1'b0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (serial_out !== 1'b1) seen = 1'b1;
    end
    chk("no_frame_after_reset", starts.size(), s);
    chk("line_idle_after_reset", {31'h0, seen}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
